// File: rtl/xslideaccum_ctrl.sv
// Sequencing controller for a sliding-window accumulator: run start/stop, history clear,
// input gating, and qualification of accumulator sums so only full-window results leave.
module xslideaccum_ctrl #(
  parameter int BWID     = 16,
  parameter int NWINDOWS = 64,
  parameter int AWID     = $clog2(NWINDOWS) + BWID,
  parameter int CWID     = $clog2(NWINDOWS) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_start,
  input  logic            i_stop,
  input  logic [BWID-1:0] iv_data,
  input  logic            i_nd,
  output logic            o_ready,
  output logic [BWID-1:0] ov_acc_data,
  output logic            o_acc_nd,
  output logic            o_acc_rst,
  input  logic [AWID-1:0] iv_acc_sum,
  input  logic            i_acc_dv,
  output logic [AWID-1:0] ov_sum,
  output logic            o_dv,
  output logic [CWID-1:0] ov_fill,
  output logic [2:0]      ov_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    FILL  = 3'd2,
    RUN   = 3'd3,
    DRAIN = 3'd4
  } state_t;

  localparam logic [CWID-1:0] FULL = CWID'(NWINDOWS);

  state_t          state, state_nxt;
  logic [1:0]      drain_cnt;
  logic            accept;
  logic [CWID-1:0] fill_inc;
  logic            fwd_tag;
  logic [1:0]      tag_pipe;
  logic            emit;

  assign accept   = i_nd & o_ready;
  assign fill_inc = (ov_fill == FULL) ? FULL : ov_fill + 1'b1;
  // A restart in the same cycle as a qualified accumulator result suppresses it too.
  assign emit     = i_acc_dv & tag_pipe[1] & ~i_start;
  assign ov_state = state;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every comb output gets a default first so no latch is inferred on unlisted paths.
  always_comb begin
    state_nxt = state;
    if (i_start) begin
      state_nxt = CLEAR;
    end else begin
      case (state)
        IDLE:  state_nxt = IDLE;
        CLEAR: state_nxt = FILL;
        FILL: begin
          if (i_stop)                          state_nxt = DRAIN;
          else if (accept && fill_inc == FULL) state_nxt = RUN;
        end
        RUN:   if (i_stop) state_nxt = DRAIN;
        DRAIN: if (drain_cnt == 2'd2) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    o_ready   = 1'b0;
    o_acc_rst = 1'b0;
    case (state)
      CLEAR:     o_acc_rst = 1'b1;
      FILL, RUN: o_ready   = 1'b1;
      default:   ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || state != DRAIN) drain_cnt <= 2'd0;
    else                       drain_cnt <= drain_cnt + 2'd1;
  end

  // Tag marks samples that complete a full window; it rides a pipe matched to the
  // forward register plus the accumulator's 2-clk latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      ov_fill     <= '0;
      o_acc_nd    <= 1'b0;
      ov_acc_data <= '0;
      fwd_tag     <= 1'b0;
      tag_pipe    <= 2'b00;
      o_dv        <= 1'b0;
      ov_sum      <= '0;
    end else begin
      o_acc_nd <= accept;
      if (accept) ov_acc_data <= iv_data;

      if (i_start)     ov_fill <= '0;
      else if (accept) ov_fill <= fill_inc;

      fwd_tag  <= accept & (fill_inc == FULL) & ~i_start;
      tag_pipe <= i_start ? 2'b00 : {tag_pipe[0], fwd_tag};

      o_dv <= emit;
      if (emit) ov_sum <= iv_acc_sum;
    end
  end

endmodule

// File: tb/tb_xslideaccum_ctrl.sv
// Self-checking bench for xslideaccum_ctrl: vector table, hand-written corner sequences,
// and randomized traffic against a queue-based reference model plus an accumulator stand-in.
module tb_xslideaccum_ctrl;

  localparam int N  = 4;
  localparam int BW = 16;
  localparam int AW = $clog2(N) + BW;
  localparam int CW = $clog2(N) + 1;

  localparam int S_IDLE = 0, S_CLEAR = 1, S_FILL = 2, S_RUN = 3, S_DRAIN = 4;

  logic          clk = 1'b0;
  logic          rst, i_start, i_stop, i_nd, i_acc_dv;
  logic [BW-1:0] iv_data, ov_acc_data;
  logic [AW-1:0] iv_acc_sum, ov_sum;
  logic          o_ready, o_acc_nd, o_acc_rst, o_dv;
  logic [CW-1:0] ov_fill;
  logic [2:0]    ov_state;

  always #5 clk = ~clk;

  xslideaccum_ctrl #(.BWID(BW), .NWINDOWS(N)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_stop(i_stop),
    .iv_data(iv_data), .i_nd(i_nd), .o_ready(o_ready),
    .ov_acc_data(ov_acc_data), .o_acc_nd(o_acc_nd), .o_acc_rst(o_acc_rst),
    .iv_acc_sum(iv_acc_sum), .i_acc_dv(i_acc_dv), .ov_sum(ov_sum), .o_dv(o_dv),
    .ov_fill(ov_fill), .ov_state(ov_state)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int wsum(input int q[$]);
    int s = 0;
    for (int i = 0; i < N && i < q.size(); i++) s += q[q.size()-1-i];
    return s;
  endfunction

  // Reference model: run phase, accepted-sample history and a schedule of expected results.
  typedef struct { int cyc; int sum; } pend_t;
  int    cyc = 0;
  int    m_st = S_IDLE, m_fill = 0, m_dleft = 0;
  int    m_hist[$];
  pend_t m_pend[$];
  int    e_state, e_ready, e_accrst, e_fill, e_nd, e_data, e_dv, e_sum;

  task automatic model_step(input logic st, input logic sp, input logic nd,
                            input logic [BW-1:0] d, input logic r);
    bit acc, found;
    int fsum;
    acc   = !r && !st && nd && (m_st == S_FILL || m_st == S_RUN);
    found = 0;
    fsum  = 0;
    while (m_pend.size() > 0 && m_pend[0].cyc <= cyc + 1) begin
      if (m_pend[0].cyc == cyc + 1) begin found = 1; fsum = m_pend[0].sum; end
      void'(m_pend.pop_front());
    end
    if (r) begin
      m_st = S_IDLE; m_fill = 0; m_dleft = 0;
      m_hist.delete(); m_pend.delete();
      e_nd = 0; e_data = 0; e_dv = 0; e_sum = 0;
    end else begin
      e_nd = acc;
      if (acc) e_data = int'(d);
      e_dv = found && !st;
      if (e_dv) e_sum = fsum;
      if (st) begin
        m_st = S_CLEAR; m_fill = 0;
        m_hist.delete(); m_pend.delete();
      end else begin
        if (acc) begin
          m_hist.push_back(int'($signed(d)));
          if (m_hist.size() > N) void'(m_hist.pop_front());
          if (m_fill < N) m_fill++;
          if (m_hist.size() == N) m_pend.push_back('{cyc + 4, wsum(m_hist)});
        end
        case (m_st)
          S_CLEAR: m_st = S_FILL;
          S_FILL, S_RUN: begin
            if (sp) begin m_st = S_DRAIN; m_dleft = 3; end
            else if (m_fill == N) m_st = S_RUN;
          end
          S_DRAIN: begin
            m_dleft--;
            if (m_dleft == 0) m_st = S_IDLE;
          end
          default: ;
        endcase
      end
    end
    e_state  = m_st;
    e_fill   = m_fill;
    e_ready  = (m_st == S_FILL || m_st == S_RUN);
    e_accrst = (m_st == S_CLEAR);
  endtask

  // Accumulator stand-in: window sum of forwarded samples, 2 clk after each forward strobe.
  int acc_hist[$];
  bit pv[2] = '{0, 0};
  int ps[2] = '{0, 0};
  int dv_log[$];

  task automatic acc_model();
    bit nv = 0;
    int ns = 0;
    if (o_acc_rst) acc_hist.delete();
    if (o_acc_nd) begin
      acc_hist.push_back(int'($signed(ov_acc_data)));
      if (acc_hist.size() > N) void'(acc_hist.pop_front());
      nv = 1;
      ns = wsum(acc_hist);
    end
    i_acc_dv   = pv[1];
    iv_acc_sum = AW'(ps[1]);
    pv[1] = pv[0]; ps[1] = ps[0];
    pv[0] = nv;    ps[0] = ns;
  endtask

  task automatic tick(input logic st, input logic sp, input logic nd,
                      input logic [BW-1:0] d, input logic r);
    rst = r; i_start = st; i_stop = sp; i_nd = nd; iv_data = d;
    model_step(st, sp, nd, d, r);
    @(posedge clk);
    cyc++;
    @(negedge clk);
    acc_model();
    if (o_dv) dv_log.push_back(int'($signed(ov_sum)));
    check("model.state",    int'(ov_state),    e_state);
    check("model.ready",    int'(o_ready),     e_ready);
    check("model.acc_rst",  int'(o_acc_rst),   e_accrst);
    check("model.fill",     int'(ov_fill),     e_fill);
    check("model.acc_nd",   int'(o_acc_nd),    e_nd);
    check("model.acc_data", int'(ov_acc_data), e_data);
    check("model.dv",       int'(o_dv),        e_dv);
    check("model.sum",      int'($signed(ov_sum)), e_sum);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, '0, 0);
  endtask

  typedef struct {
    logic          st, sp, nd;
    logic [BW-1:0] d;
    int            state, ready, accrst, fill, dv, sum;
  } vec_t;
  vec_t tbl[14];

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 16'd0, 1, 0, 1, 0, 0, 0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 16'd0, 2, 1, 0, 0, 0, 0};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 16'd1, 2, 1, 0, 1, 0, 0};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 16'd2, 2, 1, 0, 2, 0, 0};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 16'd3, 2, 1, 0, 3, 0, 0};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 16'd4, 3, 1, 0, 4, 0, 0};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 16'd5, 3, 1, 0, 4, 0, 0};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 16'd6, 3, 1, 0, 4, 0, 0};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 16'd7, 3, 1, 0, 4, 1, 10};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 16'd8, 3, 1, 0, 4, 1, 14};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 16'd0, 3, 1, 0, 4, 1, 18};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 16'd0, 3, 1, 0, 4, 1, 22};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 16'd0, 3, 1, 0, 4, 1, 26};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 16'd0, 3, 1, 0, 4, 0, 26};

    rst = 1'b1; i_start = 1'b0; i_stop = 1'b0; i_nd = 1'b0; iv_data = '0;
    i_acc_dv = 1'b0; iv_acc_sum = '0;
    @(negedge clk);

    // Reset state
    tick(0, 0, 0, '0, 1);
    tick(0, 0, 0, '0, 1);
    check("reset.state", int'(ov_state), S_IDLE);
    check("reset.dv",    int'(o_dv), 0);
    check("reset.sum",   int'(ov_sum), 0);

    // Continuous stream 1,2,3,...
    for (int i = 0; i < 14; i++) begin
      tick(tbl[i].st, tbl[i].sp, tbl[i].nd, tbl[i].d, 1'b0);
      check($sformatf("tbl%0d.state", i),   int'(ov_state),  tbl[i].state);
      check($sformatf("tbl%0d.ready", i),   int'(o_ready),   tbl[i].ready);
      check($sformatf("tbl%0d.acc_rst", i), int'(o_acc_rst), tbl[i].accrst);
      check($sformatf("tbl%0d.fill", i),    int'(ov_fill),   tbl[i].fill);
      check($sformatf("tbl%0d.dv", i),      int'(o_dv),      tbl[i].dv);
      check($sformatf("tbl%0d.sum", i),     int'($signed(ov_sum)), tbl[i].sum);
    end

    // Gapped samples -5, 7, -1, 3, 2 every third cycle
    tick(0, 0, 0, '0, 1);
    dv_log.delete();
    tick(1, 0, 0, '0, 0);
    idle(1);
    begin
      int gs[5] = '{-5, 7, -1, 3, 2};
      for (int i = 0; i < 5; i++) begin
        tick(0, 0, 1, BW'(gs[i]), 0);
        idle(2);
      end
    end
    idle(4);
    check("gap.count", dv_log.size(), 2);
    if (dv_log.size() == 2) begin
      check("gap.sum0", dv_log[0], 4);
      check("gap.sum1", dv_log[1], 11);
    end
    check("gap.fill", int'(ov_fill), N);

    // Restart mid-RUN: in-flight sums suppressed, fresh history
    tick(0, 0, 0, '0, 1);
    dv_log.delete();
    tick(1, 0, 0, '0, 0);
    idle(1);
    for (int i = 1; i <= 6; i++) tick(0, 0, 1, BW'(i), 0);
    tick(1, 0, 0, '0, 0);
    check("restart.state", int'(ov_state), S_CLEAR);
    check("restart.acc_rst", int'(o_acc_rst), 1);
    idle(1);
    for (int i = 0; i < 4; i++) tick(0, 0, 1, 16'd10, 0);
    idle(5);
    check("restart.count", dv_log.size(), 1);
    if (dv_log.size() == 1) check("restart.sum", dv_log[0], 40);

    // Stop in RUN: last accepted sample still emitted, DRAIN ignores input
    tick(0, 0, 0, '0, 1);
    dv_log.delete();
    tick(1, 0, 0, '0, 0);
    idle(1);
    for (int i = 1; i <= 5; i++) tick(0, 0, 1, BW'(i), 0);
    tick(0, 1, 1, 16'd6, 0);
    check("stop.ready_t1", int'(o_ready), 0);
    check("stop.state_t1", int'(ov_state), S_DRAIN);
    for (int i = 0; i < 3; i++) tick(0, 0, 1, 16'd100, 0);
    check("stop.state_t4", int'(ov_state), S_IDLE);
    check("stop.dv_t4", int'(o_dv), 1);
    check("stop.sum_t4", int'($signed(ov_sum)), 18);
    idle(3);
    check("stop.count", dv_log.size(), 3);
    if (dv_log.size() == 3) check("stop.last", dv_log[2], 18);

    // Start and stop together in FILL; stop in IDLE
    tick(0, 0, 0, '0, 1);
    tick(1, 0, 0, '0, 0);
    idle(1);
    tick(0, 0, 1, 16'd1, 0);
    tick(0, 0, 1, 16'd2, 0);
    tick(1, 1, 0, '0, 0);
    check("startstop.state", int'(ov_state), S_CLEAR);
    tick(0, 0, 0, '0, 1);
    tick(0, 1, 0, '0, 0);
    check("idlestop.state", int'(ov_state), S_IDLE);

    // Reset while results are pending
    tick(1, 0, 0, '0, 0);
    idle(1);
    for (int i = 1; i <= 6; i++) tick(0, 0, 1, BW'(i), 0);
    tick(0, 0, 1, 16'd7, 1);
    dv_log.delete();
    check("rst.state",    int'(ov_state), 0);
    check("rst.ready",    int'(o_ready), 0);
    check("rst.acc_nd",   int'(o_acc_nd), 0);
    check("rst.acc_data", int'(ov_acc_data), 0);
    check("rst.fill",     int'(ov_fill), 0);
    check("rst.dv",       int'(o_dv), 0);
    check("rst.sum",      int'(ov_sum), 0);
    idle(6);
    check("rst.no_dv_after", dv_log.size(), 0);

    // Randomized traffic against the reference model
    for (int i = 0; i < 3000; i++) begin
      logic r, st, sp, nd;
      r  = ($urandom_range(0, 299) == 0);
      st = ($urandom_range(0, 39) == 0);
      sp = ($urandom_range(0, 29) == 0);
      nd = st ? 1'b0 : ($urandom_range(0, 9) < 6);
      tick(st, sp, nd, BW'($urandom), r);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
